// File: rtl/selector_pkg.sv
// ---------------------------------------------------------------------------
// selector_pkg
// Shared definitions for the selector41_tdm time-division selector:
//   - state_t   : frame FSM states (IDLE, SEND)
//   - SLOT0..3  : slot index constants
//   - SLOT_LAST : final slot of a frame, where the next frame may be loaded
// ---------------------------------------------------------------------------
package selector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [1:0] SLOT0     = 2'd0;
  localparam logic [1:0] SLOT1     = 2'd1;
  localparam logic [1:0] SLOT2     = 2'd2;
  localparam logic [1:0] SLOT3     = 2'd3;
  localparam logic [1:0] SLOT_LAST = SLOT3;

endpackage : selector_pkg

// File: rtl/selector41_slot_cnt.sv
// ---------------------------------------------------------------------------
// selector41_slot_cnt
// 2-bit slot counter with synchronous clear, enable and natural 3->0 wrap.
// Ports:
//   iClk, iRst_n : clock (rising edge), asynchronous active-low reset
//   clr          : force slot to 0 on the next edge (priority over en)
//   en           : advance slot by one on the next edge
//   slot         : current slot (registered)
//   slot_nxt     : value slot takes on the next edge, so the parent can
//                  register slot-dependent outputs in the same cycle
//   last         : slot == SLOT_LAST
// ---------------------------------------------------------------------------
module selector41_slot_cnt
  import selector_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] slot,
  output logic [1:0] slot_nxt,
  output logic       last
);

  logic [1:0] slot_q;
  logic [1:0] slot_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = SLOT0;
    end else if (en) begin
      slot_d = slot_q + 2'd1;  // 2-bit add wraps 3 -> 0 by itself
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      slot_q <= SLOT0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot     = slot_q;
  assign slot_nxt = slot_d;
  assign last     = (slot_q == SLOT_LAST);

endmodule : selector41_slot_cnt

// File: rtl/selector41_tdm.sv
// ---------------------------------------------------------------------------
// selector41_tdm
// Time-division 4-to-1 selector. Captures iC0..iC3 in one handshake and
// emits them serially, one per slot, with the slot index on {oS1,oS0} and a
// start-of-frame flag. Feeds a 1-to-4 de-selector directly.
//
// Parameters:
//   WIDTH      : data width of each channel and of oZ
// Ports:
//   iClk       : clock, rising edge
//   iRst_n     : asynchronous active-low reset
//   iC0..iC3   : parallel channel data, sampled only on the accepting edge
//   iValid     : upstream frame valid (held until accepted)
//   oReady     : frame can be accepted this cycle (combinational)
//   iReady     : downstream accepts the current slot
//   oZ         : serialized slot data (registered)
//   oS1, oS0   : slot select, {oS1,oS0} = slot index (registered)
//   oValid     : oZ/oS valid (registered)
//   oSof       : high during slot 0 of every frame (registered)
//   oP         : even parity of oZ, 0 when oValid=0 (registered)
//                only present when SELECTOR41_TDM_PARITY_EN is defined
// ---------------------------------------------------------------------------
module selector41_tdm
  import selector_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iC0,
  input  logic [WIDTH-1:0] iC1,
  input  logic [WIDTH-1:0] iC2,
  input  logic [WIDTH-1:0] iC3,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iReady,
  output logic [WIDTH-1:0] oZ,
  output logic             oS1,
  output logic             oS0,
  output logic             oValid,
  output logic             oSof
`ifdef SELECTOR41_TDM_PARITY_EN
  ,
  output logic             oP
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] h_q [4];
  logic [WIDTH-1:0] h_d [4];

  logic [WIDTH-1:0] z_q, z_d;
  logic [1:0]       s_q, s_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;

  logic [1:0]       slot;
  logic [1:0]       slot_nxt;
  logic             last;
  logic             accept;
  logic             advance;

  // A new frame may enter from IDLE, or in SEND on the very cycle the last
  // slot is consumed, which gives back-to-back frames with no bubble.
  assign oReady  = (state_q == IDLE) || ((state_q == SEND) && last && iReady);
  assign accept  = iValid && oReady;
  assign advance = (state_q == SEND) && iReady;

  selector41_slot_cnt u_slot_cnt (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .clr      (accept),
    .en       (advance),
    .slot     (slot),
    .slot_nxt (slot_nxt),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (iReady && last && !iValid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      h_d[0] = iC0;
      h_d[1] = iC1;
      h_d[2] = iC2;
      h_d[3] = iC3;
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // slot the counter moves to; a stall leaves every input here unchanged.
  always_comb begin
    valid_d = (state_d == SEND);
    z_d     = valid_d ? h_d[slot_nxt] : '0;
    s_d     = valid_d ? slot_nxt : SLOT0;
    sof_d   = valid_d && (slot_nxt == SLOT0);
  end

  // NOTE: the four hold registers are reset like the rest of the state; it
  // is only 4*WIDTH flops, and it keeps oZ deterministic out of reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) h_q[i] <= '0;
      z_q     <= '0;
      s_q     <= SLOT0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      z_q     <= z_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
    end
  end

  assign oZ     = z_q;
  assign oS1    = s_q[1];
  assign oS0    = s_q[0];
  assign oValid = valid_q;
  assign oSof   = sof_q;

`ifdef SELECTOR41_TDM_PARITY_EN
  // z_d is already zero when the slot is not valid, so parity is 0 then too.
  logic p_q;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      p_q <= 1'b0;
    end else begin
      p_q <= ^z_d;
    end
  end
  assign oP = p_q;
`endif

endmodule : selector41_tdm

// File: tb/tb_selector41_tdm.sv
// ---------------------------------------------------------------------------
// tb_selector41_tdm
// Self-checking bench for selector41_tdm with WIDTH=4. A vector table covers
// single frame, stall, input isolation, ignored iValid and back-to-back
// frames; hand-written sequences cover reset, asynchronous mid-frame reset
// and parity (when SELECTOR41_TDM_PARITY_EN is defined).
// ---------------------------------------------------------------------------
module tb_selector41_tdm;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] c0, c1, c2, c3;
  logic             in_valid;
  logic             out_ready;
  logic             in_ready;
  logic [WIDTH-1:0] z;
  logic             s1, s0;
  logic             out_valid;
  logic             sof;
`ifdef SELECTOR41_TDM_PARITY_EN
  logic             p;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  selector41_tdm #(.WIDTH(WIDTH)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iC0    (c0),
    .iC1    (c1),
    .iC2    (c2),
    .iC3    (c3),
    .iValid (in_valid),
    .oReady (out_ready),
    .iReady (in_ready),
    .oZ     (z),
    .oS1    (s1),
    .oS0    (s0),
    .oValid (out_valid),
    .oSof   (sof)
`ifdef SELECTOR41_TDM_PARITY_EN
    ,
    .oP     (p)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One table row: inputs held for one clock, oReady expected before the
  // edge, registered outputs expected after it.
  typedef struct packed {
    logic [3:0] c0, c1, c2, c3;
    logic       valid;
    logic       rdy;
    logic       exp_ready;
    logic [3:0] exp_z;
    logic [1:0] exp_s;
    logic       exp_valid;
    logic       exp_sof;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] a, b, c, d,
                              input logic v, r, er,
                              input logic [3:0] ez, input logic [1:0] es,
                              input logic ev, esof);
    vec_t t;
    t.c0 = a; t.c1 = b; t.c2 = c; t.c3 = d;
    t.valid = v; t.rdy = r; t.exp_ready = er;
    t.exp_z = ez; t.exp_s = es; t.exp_valid = ev; t.exp_sof = esof;
    return t;
  endfunction

  vec_t vecs [13];

  task automatic check_outputs(input string tag, input logic [3:0] ez,
                               input logic [1:0] es, input logic ev,
                               input logic esof);
    check({tag, " oZ"},     32'(z),         32'(ez));
    check({tag, " oS"},     32'({s1, s0}),  32'(es));
    check({tag, " oValid"}, 32'(out_valid), 32'(ev));
    check({tag, " oSof"},   32'(sof),       32'(esof));
`ifdef SELECTOR41_TDM_PARITY_EN
    check({tag, " oP"},     32'(p),         32'(^ez));
`endif
  endtask

  initial begin
    // cycle    : inputs                      | ready | after edge: z, s, v, sof
    vecs[0]  = mk(4'h1, 4'h2, 4'h3, 4'h4, 1, 1, 1, 4'h1, 2'd0, 1, 1); // accept
    vecs[1]  = mk(4'hF, 4'hF, 4'hF, 4'hF, 0, 1, 0, 4'h2, 2'd1, 1, 0); // iC change
    vecs[2]  = mk(4'hF, 4'hF, 4'hF, 4'hF, 1, 0, 0, 4'h2, 2'd1, 1, 0); // stall, iValid ignored
    vecs[3]  = mk(4'hF, 4'hF, 4'hF, 4'hF, 1, 0, 0, 4'h2, 2'd1, 1, 0); // stall
    vecs[4]  = mk(4'hF, 4'hF, 4'hF, 4'hF, 1, 0, 0, 4'h2, 2'd1, 1, 0); // stall
    vecs[5]  = mk(4'hF, 4'hF, 4'hF, 4'hF, 0, 1, 0, 4'h3, 2'd2, 1, 0);
    vecs[6]  = mk(4'hF, 4'hF, 4'hF, 4'hF, 0, 1, 0, 4'h4, 2'd3, 1, 0);
    vecs[7]  = mk(4'hA, 4'hB, 4'hC, 4'hD, 1, 1, 1, 4'hA, 2'd0, 1, 1); // back-to-back
    vecs[8]  = mk(4'h5, 4'h5, 4'h5, 4'h5, 0, 1, 0, 4'hB, 2'd1, 1, 0);
    vecs[9]  = mk(4'h5, 4'h5, 4'h5, 4'h5, 0, 1, 0, 4'hC, 2'd2, 1, 0);
    vecs[10] = mk(4'h5, 4'h5, 4'h5, 4'h5, 0, 1, 0, 4'hD, 2'd3, 1, 0);
    vecs[11] = mk(4'h5, 4'h5, 4'h5, 4'h5, 0, 1, 1, 4'h0, 2'd0, 0, 0); // to IDLE
    vecs[12] = mk(4'h5, 4'h5, 4'h5, 4'h5, 0, 0, 1, 4'h0, 2'd0, 0, 0); // idle

    rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    c0 = '0; c1 = '0; c2 = '0; c3 = '0;

    // Reset state
    #12;
    check_outputs("reset", 4'h0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("reset oReady", 32'(out_ready), 32'd1);
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      c0 = vecs[i].c0; c1 = vecs[i].c1; c2 = vecs[i].c2; c3 = vecs[i].c3;
      in_valid = vecs[i].valid;
      in_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d oReady", i), 32'(out_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_z, vecs[i].exp_s,
                    vecs[i].exp_valid, vecs[i].exp_sof);
    end

    // Parity words 0111 / 0101, then asynchronous reset mid-frame
    c0 = 4'b0111; c1 = 4'b0101; c2 = 4'h9; c3 = 4'h6;
    in_valid = 1'b1; in_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_outputs("par0", 4'b0111, 2'd0, 1'b1, 1'b1);
`ifdef SELECTOR41_TDM_PARITY_EN
    check("par0 oP=1", 32'(p), 32'd1);
`endif
    @(posedge clk); #1;
    check_outputs("par1", 4'b0101, 2'd1, 1'b1, 1'b0);
`ifdef SELECTOR41_TDM_PARITY_EN
    check("par1 oP=0", 32'(p), 32'd0);
`endif
    #2;  // mid-cycle, away from any clock edge
    rst_n = 1'b0;
    #1;
    check_outputs("async rst", 4'h0, 2'd0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    #1;
    check("post-rst oReady", 32'(out_ready), 32'd1);
    @(posedge clk); #1;
    check_outputs("post-rst idle", 4'h0, 2'd0, 1'b0, 1'b0);

    // Remaining slots must not reappear after reset
    @(posedge clk); #1;
    check("discarded oValid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule : tb_selector41_tdm
